placement_readback: RTL and testbench
=====================================

Name: placement_readback

Overview:
- Reads back a finished placement. Scans the grid RAM cell by cell and cross-checks each occupied cell against the pos_X/pos_Y RAMs.
- Streams one (node, x, y) record per placed node over a valid/ready interface and reports placed/mismatch counts.
- Sits after the placement engine and drives the read ports of the same grid and position memoryRAM instances once placement raises out.

Parameters:
- N, 6, grid side; grid holds N*N cells, address = x*N + y.
- N_NODES, 128, size of the position RAMs (2^tam_pos_mem); node ids >= N_NODES are invalid.
- READ_LAT, 2, cycles from a re pulse to the cycle dout is sampled.
- EMPTY, -1, 32-bit signed grid/position value meaning "unused".

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a scan; ignored unless in IDLE
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  one-cycle pulse when the scan completes
- grid_re  out  1  grid read enable, single-cycle pulse
- grid_addr  out  32  grid cell address
- grid_dout  in  32  grid read data, signed
- px_re  out  1  pos_X read enable
- px_addr  out  32  pos_X address = node id
- px_dout  in  32  pos_X read data
- py_re  out  1  pos_Y read enable
- py_addr  out  32  pos_Y address = node id
- py_dout  in  32  pos_Y read data
- out_valid  out  1  record valid
- out_ready  in  1  downstream accepts record
- out_node  out  32  node id
- out_x  out  32  grid row
- out_y  out  32  grid column
- placed_cnt  out  32  records emitted this scan
- mismatch_cnt  out  32  consistency errors this scan
- dup_cnt  out  32  duplicate occurrences (see Optional Feature)

Behaviour:
- Reset: return to IDLE in the same cycle. All outputs 0 (re strobes, addresses, busy, done, out_valid, out_*, all counters). Reset mid-scan aborts with no done pulse.
- States:
  - IDLE -> G_REQ on start; clear counters and the x/y scan indices.
  - G_REQ: grid_re=1, grid_addr=x*N+y -> G_WAIT.
  - G_WAIT: count READ_LAT-1 cycles -> G_CHK, sampling grid_dout into node.
  - G_CHK: if node==EMPTY -> ADV. If node<0 or node>=N_NODES -> mismatch_cnt++ -> ADV. Else -> P_REQ.
  - P_REQ: px_re=py_re=1, px_addr=py_addr=node -> P_WAIT.
  - P_WAIT: READ_LAT-1 cycles -> P_CHK.
  - P_CHK: if px_dout!=x or py_dout!=y -> mismatch_cnt++ -> ADV. Else load out_node/out_x/out_y and set out_valid -> EMIT.
  - EMIT: hold out_valid and out_* stable until the cycle out_ready=1. On that transfer: out_valid<=0, placed_cnt++ -> ADV. out_ready while out_valid=0 has no effect.
  - ADV: y++. When y==N-1, wrap y to 0 and x++. When x==N-1 and y==N-1 -> DONE, else -> G_REQ.
  - DONE: done=1 for one cycle, busy=0 -> IDLE. Counters hold until the next start.
- Read strobes are high exactly one cycle per request. At most one memory request is outstanding at a time.
- Cell (N-1,N-1) is always scanned. Total cells scanned = N*N. A grid of all EMPTY gives placed_cnt=0 and done after N*N*(READ_LAT+2) cycles.
- Comparisons and counters are 32-bit. Ids and positions are treated as signed.

Optional Feature:
- Macro: PLACEMENT_READBACK_DUP_CHECK_EN.
- Defined:
  - Keep an N_NODES-bit seen bitmap, cleared on start and on reset.
  - In G_CHK, a valid node whose seen bit is already set: dup_cnt++, skip its record (-> ADV).
  - Otherwise set the seen bit and proceed to P_REQ.
- Undefined: no bitmap; dup_cnt tied to 0; duplicates go through the normal position check.

Test Plan:
- Reset mid-scan (after 10 cells) -> busy=0, out_valid=0, all counters 0, no done pulse. A following start scans from cell 0.
- N=6, grid all EMPTY, start -> done after 36 cells, placed_cnt=0, mismatch_cnt=0, no out_valid.
- Grid cell 14 = node 3, posX[3]=2, posY[3]=2, out_ready=1 -> one record (3,2,2), placed_cnt=1, mismatch_cnt=0.
- Same setup but posY[3]=4 -> no record, mismatch_cnt=1. Grid cell 0 = 200 -> mismatch_cnt increments, px_re never pulses.
- Backpressure: out_ready=0 for 5 cycles with a pending record -> out_valid and out_* stay stable for those 5 cycles; exactly one transfer once out_ready=1.
- Node 5 in cells 7 and 20, posX/posY[5]=(1,1):
  - With PLACEMENT_READBACK_DUP_CHECK_EN: placed_cnt=1, dup_cnt=1, mismatch_cnt=0.
  - Without the macro: placed_cnt=1, mismatch_cnt=1, dup_cnt=0.

Source files
------------

// File: rtl/placement_readback_if.sv
// placement_readback_if
//   Bundles the memory read ports (grid, pos_X, pos_Y) and the record
//   output stream used by placement_readback.
//   master : the readback engine (drives read strobes/addresses and records)
//   slave  : memories + downstream consumer
//   grid_re/grid_addr/grid_dout : grid RAM read port
//   px_re/px_addr/px_dout       : pos_X RAM read port
//   py_re/py_addr/py_dout       : pos_Y RAM read port
//   out_valid/out_ready/out_node/out_x/out_y : (node, x, y) record stream
interface placement_readback_if;
   logic        grid_re;
   logic [31:0] grid_addr;
   logic [31:0] grid_dout;
   logic        px_re;
   logic [31:0] px_addr;
   logic [31:0] px_dout;
   logic        py_re;
   logic [31:0] py_addr;
   logic [31:0] py_dout;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_node;
   logic [31:0] out_x;
   logic [31:0] out_y;

   modport master (
      output grid_re, grid_addr, input grid_dout,
      output px_re, px_addr, input px_dout,
      output py_re, py_addr, input py_dout,
      output out_valid, out_node, out_x, out_y, input out_ready
   );

   modport slave (
      input grid_re, grid_addr, output grid_dout,
      input px_re, px_addr, output px_dout,
      input py_re, py_addr, output py_dout,
      input out_valid, out_node, out_x, out_y, output out_ready
   );
endinterface

// File: rtl/placement_readback.sv
// placement_readback
//   Scans a finished placement: walks every grid cell (address x*N+y),
//   looks each occupied cell's node up in pos_X/pos_Y and streams one
//   (node, x, y) record per consistently placed node.
//   Optional build macro PLACEMENT_READBACK_DUP_CHECK_EN adds a seen-bitmap
//   that counts and skips repeated node ids (dup_cnt); otherwise dup_cnt=0.
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   start        : scan request pulse (IDLE only)
//   busy, done   : scan in progress / one-cycle completion pulse
//   bus          : memory read ports + record stream (master side)
//   placed_cnt   : records transferred this scan
//   mismatch_cnt : invalid ids and position disagreements this scan
//   dup_cnt      : repeated node ids this scan (feature build only)
//
// state  | meaning
// IDLE   | waiting for start, counters hold
// G_REQ  | grid read strobe for cell (x,y)
// G_WAIT | read latency, capture grid word as node
// G_CHK  | classify node: empty / invalid / duplicate / lookup
// P_REQ  | pos_X/pos_Y read strobes for node
// P_WAIT | read latency, capture positions
// P_CHK  | compare positions against (x,y)
// EMIT   | record held on the stream until accepted
// ADV    | step to next cell or finish
// DONE   | done pulse, then IDLE
module placement_readback #(
   parameter int N        = 6,
   parameter int N_NODES  = 128,
   parameter int READ_LAT = 2,
   parameter int EMPTY    = -1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   placement_readback_if.master bus,
   output logic [31:0] placed_cnt,
   output logic [31:0] mismatch_cnt,
   output logic [31:0] dup_cnt
);
   localparam logic [3:0] IDLE   = 4'd0;
   localparam logic [3:0] G_REQ  = 4'd1;
   localparam logic [3:0] G_WAIT = 4'd2;
   localparam logic [3:0] G_CHK  = 4'd3;
   localparam logic [3:0] P_REQ  = 4'd4;
   localparam logic [3:0] P_WAIT = 4'd5;
   localparam logic [3:0] P_CHK  = 4'd6;
   localparam logic [3:0] EMIT   = 4'd7;
   localparam logic [3:0] ADV    = 4'd8;
   localparam logic [3:0] DONE   = 4'd9;

   // Wait counter terminal count is 0; the request cycle itself is one of
   // the READ_LAT cycles, so the wait state lasts READ_LAT-1 cycles.
   localparam logic [7:0] WAIT_INIT = 8'(READ_LAT - 2);

   logic [3:0]         state_q, state_d;
   logic [31:0]        x_q, x_d, y_q, y_d;
   logic [7:0]         wait_q, wait_d;
   logic signed [31:0] node_q, node_d;
   logic [31:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic               grid_re_q, grid_re_d, p_re_q, p_re_d;
   logic [31:0]        grid_addr_q, grid_addr_d, p_addr_q, p_addr_d;
   logic               out_valid_q, out_valid_d;
   logic [31:0]        out_node_q, out_node_d, out_x_q, out_x_d, out_y_q, out_y_d;
   logic [31:0]        placed_q, placed_d, mism_q, mism_d;
   logic               busy_q, busy_d, done_q, done_d;
`ifdef PLACEMENT_READBACK_DUP_CHECK_EN
   localparam int IDW = $clog2(N_NODES);
   logic [N_NODES-1:0] seen_q, seen_d;
   logic [31:0]        dup_q, dup_d;
   logic [IDW-1:0]     node_idx;
   assign node_idx = node_q[IDW-1:0];
`endif

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      wait_d      = wait_q;
      node_d      = node_q;
      pos_x_d     = pos_x_q;
      pos_y_d     = pos_y_q;
      grid_re_d   = 1'b0;
      grid_addr_d = grid_addr_q;
      p_re_d      = 1'b0;
      p_addr_d    = p_addr_q;
      out_valid_d = out_valid_q;
      out_node_d  = out_node_q;
      out_x_d     = out_x_q;
      out_y_d     = out_y_q;
      placed_d    = placed_q;
      mism_d      = mism_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
`ifdef PLACEMENT_READBACK_DUP_CHECK_EN
      seen_d      = seen_q;
      dup_d       = dup_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = G_REQ;
               x_d         = '0;
               y_d         = '0;
               placed_d    = '0;
               mism_d      = '0;
               busy_d      = 1'b1;
               grid_re_d   = 1'b1;
               grid_addr_d = '0;
`ifdef PLACEMENT_READBACK_DUP_CHECK_EN
               seen_d      = '0;
               dup_d       = '0;
`endif
            end
         end
         G_REQ: begin
            state_d = G_WAIT;
            wait_d  = WAIT_INIT;
         end
         G_WAIT: begin
            if (wait_q == 8'd0) begin
               node_d  = bus.grid_dout;
               state_d = G_CHK;
            end else begin
               wait_d = wait_q - 8'd1;
            end
         end
         G_CHK: begin
            if (node_q == EMPTY) begin
               state_d = ADV;
            end else if (node_q < 0 || node_q >= N_NODES) begin
               mism_d  = mism_q + 32'd1;
               state_d = ADV;
`ifdef PLACEMENT_READBACK_DUP_CHECK_EN
            end else if (seen_q[node_idx]) begin
               dup_d   = dup_q + 32'd1;
               state_d = ADV;
`endif
            end else begin
`ifdef PLACEMENT_READBACK_DUP_CHECK_EN
               seen_d[node_idx] = 1'b1;
`endif
               p_re_d   = 1'b1;
               p_addr_d = node_q;
               state_d  = P_REQ;
            end
         end
         P_REQ: begin
            state_d = P_WAIT;
            wait_d  = WAIT_INIT;
         end
         P_WAIT: begin
            if (wait_q == 8'd0) begin
               pos_x_d = bus.px_dout;
               pos_y_d = bus.py_dout;
               state_d = P_CHK;
            end else begin
               wait_d = wait_q - 8'd1;
            end
         end
         P_CHK: begin
            if (pos_x_q != x_q || pos_y_q != y_q) begin
               mism_d  = mism_q + 32'd1;
               state_d = ADV;
            end else begin
               out_valid_d = 1'b1;
               out_node_d  = node_q;
               out_x_d     = x_q;
               out_y_d     = y_q;
               state_d     = EMIT;
            end
         end
         EMIT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               placed_d    = placed_q + 32'd1;
               state_d     = ADV;
            end
         end
         ADV: begin
            if (y_q == 32'(N - 1)) begin
               y_d = '0;
               x_d = x_q + 32'd1;
            end else begin
               y_d = y_q + 32'd1;
            end
            if (x_q == 32'(N - 1) && y_q == 32'(N - 1)) begin
               state_d = DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               state_d     = G_REQ;
               grid_re_d   = 1'b1;
               grid_addr_d = x_d * 32'(N) + y_d;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         wait_q      <= '0;
         node_q      <= '0;
         pos_x_q     <= '0;
         pos_y_q     <= '0;
         grid_re_q   <= 1'b0;
         grid_addr_q <= '0;
         p_re_q      <= 1'b0;
         p_addr_q    <= '0;
         out_valid_q <= 1'b0;
         out_node_q  <= '0;
         out_x_q     <= '0;
         out_y_q     <= '0;
         placed_q    <= '0;
         mism_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef PLACEMENT_READBACK_DUP_CHECK_EN
         seen_q      <= '0;
         dup_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         wait_q      <= wait_d;
         node_q      <= node_d;
         pos_x_q     <= pos_x_d;
         pos_y_q     <= pos_y_d;
         grid_re_q   <= grid_re_d;
         grid_addr_q <= grid_addr_d;
         p_re_q      <= p_re_d;
         p_addr_q    <= p_addr_d;
         out_valid_q <= out_valid_d;
         out_node_q  <= out_node_d;
         out_x_q     <= out_x_d;
         out_y_q     <= out_y_d;
         placed_q    <= placed_d;
         mism_q      <= mism_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef PLACEMENT_READBACK_DUP_CHECK_EN
         seen_q      <= seen_d;
         dup_q       <= dup_d;
`endif
      end
   end

   assign bus.grid_re   = grid_re_q;
   assign bus.grid_addr = grid_addr_q;
   assign bus.px_re     = p_re_q;
   assign bus.px_addr   = p_addr_q;
   assign bus.py_re     = p_re_q;
   assign bus.py_addr   = p_addr_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_node  = out_node_q;
   assign bus.out_x     = out_x_q;
   assign bus.out_y     = out_y_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign placed_cnt    = placed_q;
   assign mismatch_cnt  = mism_q;
`ifdef PLACEMENT_READBACK_DUP_CHECK_EN
   assign dup_cnt       = dup_q;
`else
   assign dup_cnt       = '0;
`endif
endmodule

// File: tb/tb_placement_readback.sv
module tb_placement_readback;
   localparam int N       = 6;
   localparam int NC      = N * N;
   localparam int N_NODES = 128;
   localparam int BUDGET  = 6000;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy, done;
   logic [31:0] placed_cnt, mismatch_cnt, dup_cnt;

   placement_readback_if bus ();

   placement_readback #(.N(N), .N_NODES(N_NODES), .READ_LAT(2), .EMPTY(-1)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .bus          (bus),
      .placed_cnt   (placed_cnt),
      .mismatch_cnt (mismatch_cnt),
      .dup_cnt      (dup_cnt)
   );

   always #5 clk = ~clk;

   int grid_mem [NC];
   int posx_mem [N_NODES];
   int posy_mem [N_NODES];

   // Synchronous RAMs: data appears the edge after the strobe and holds.
   always @(posedge clk) begin
      if (bus.grid_re)
         bus.grid_dout <= (bus.grid_addr < 32'(NC)) ? grid_mem[int'(bus.grid_addr)] : 32'hDEAD_BEEF;
      if (bus.px_re)
         bus.px_dout <= (bus.px_addr < 32'(N_NODES)) ? posx_mem[int'(bus.px_addr)] : 32'hDEAD_BEEF;
      if (bus.py_re)
         bus.py_dout <= (bus.py_addr < 32'(N_NODES)) ? posy_mem[int'(bus.py_addr)] : 32'hDEAD_BEEF;
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Reference model: walks the cells in order and applies the readback rules.
   int exp_node[$], exp_x[$], exp_y[$];
   int exp_placed, exp_mism, exp_dup, exp_plook;

   function automatic void build_expect();
      bit seen [N_NODES];
      exp_node.delete(); exp_x.delete(); exp_y.delete();
      exp_placed = 0; exp_mism = 0; exp_dup = 0; exp_plook = 0;
      foreach (seen[i]) seen[i] = 1'b0;
      for (int c = 0; c < NC; c++) begin
         int nd, cx, cy;
         nd = grid_mem[c];
         cx = c / N;
         cy = c % N;
         if (nd == -1) continue;
         if (nd < 0 || nd >= N_NODES) begin
            exp_mism++;
            continue;
         end
`ifdef PLACEMENT_READBACK_DUP_CHECK_EN
         if (seen[nd]) begin
            exp_dup++;
            continue;
         end
         seen[nd] = 1'b1;
`endif
         exp_plook++;
         if (posx_mem[nd] != cx || posy_mem[nd] != cy) begin
            exp_mism++;
         end else begin
            exp_placed++;
            exp_node.push_back(nd);
            exp_x.push_back(cx);
            exp_y.push_back(cy);
         end
      end
   endfunction

   task automatic clear_mems();
      foreach (grid_mem[i]) grid_mem[i] = -1;
      foreach (posx_mem[i]) posx_mem[i] = -1;
      foreach (posy_mem[i]) posy_mem[i] = -1;
   endtask

   // rmode: 0 always ready, 1 random ready, 2 stall 5 cycles per record
   task automatic run_scan(input string name, input int rmode, output int cyc);
      int          gre, pre, stall_left, stalled, ntx;
      bit          got_done, prev_stall;
      logic [31:0] pv_node, pv_x, pv_y;
      build_expect();
      gre = 0; pre = 0; stall_left = 0; stalled = 0; ntx = 0;
      got_done = 1'b0; prev_stall = 1'b0;
      pv_node = '0; pv_x = '0; pv_y = '0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      check_eq({name, ":busy_start"}, {31'b0, busy}, 32'd1);
      while (!got_done && cyc < BUDGET) begin
         if (bus.out_valid && !prev_stall) stall_left = (rmode == 2) ? 5 : 0;
         case (rmode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = 1'($urandom_range(0, 1));
            default: begin
               if (bus.out_valid && stall_left > 0) begin
                  bus.out_ready = 1'b0;
                  stall_left--;
               end else begin
                  bus.out_ready = 1'b1;
               end
            end
         endcase
         if (prev_stall) begin
            check_eq({name, ":valid_hold"}, {31'b0, bus.out_valid}, 32'd1);
            check_eq({name, ":node_hold"}, bus.out_node, pv_node);
            check_eq({name, ":x_hold"}, bus.out_x, pv_x);
            check_eq({name, ":y_hold"}, bus.out_y, pv_y);
            stalled++;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_node.size() == 0) begin
               check_eq({name, ":extra_record"}, 32'd1, 32'd0);
            end else begin
               check_eq({name, ":rec_node"}, bus.out_node, 32'(exp_node.pop_front()));
               check_eq({name, ":rec_x"}, bus.out_x, 32'(exp_x.pop_front()));
               check_eq({name, ":rec_y"}, bus.out_y, 32'(exp_y.pop_front()));
            end
            if (rmode == 2) check_eq({name, ":stall_cycles"}, 32'(stalled), 32'd5);
            stalled = 0;
            ntx++;
         end
         if (bus.grid_re) begin
            check_eq({name, ":grid_addr"}, bus.grid_addr, 32'(gre));
            gre++;
         end
         if (bus.px_re) pre++;
         if (done) got_done = 1'b1;
         prev_stall = bus.out_valid && !bus.out_ready;
         pv_node = bus.out_node; pv_x = bus.out_x; pv_y = bus.out_y;
         if (!got_done) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
         end
      end
      check_eq({name, ":done_seen"}, {31'b0, got_done}, 32'd1);
      check_eq({name, ":busy_at_done"}, {31'b0, busy}, 32'd0);
      check_eq({name, ":grid_reads"}, 32'(gre), 32'(NC));
      check_eq({name, ":pos_reads"}, 32'(pre), 32'(exp_plook));
      check_eq({name, ":records"}, 32'(ntx), 32'(exp_placed));
      check_eq({name, ":placed_cnt"}, placed_cnt, 32'(exp_placed));
      check_eq({name, ":mismatch_cnt"}, mismatch_cnt, 32'(exp_mism));
      check_eq({name, ":dup_cnt"}, dup_cnt, 32'(exp_dup));
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq({name, ":done_pulse"}, {31'b0, done}, 32'd0);
      check_eq({name, ":placed_hold"}, placed_cnt, 32'(exp_placed));
   endtask

   initial begin
      int cyc, gre, ndone;
      reset = 1'b1;
      start = 1'b0;
      bus.out_ready = 1'b1;
      clear_mems();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst:busy", {31'b0, busy}, 32'd0);
      check_eq("rst:done", {31'b0, done}, 32'd0);
      check_eq("rst:grid_re", {31'b0, bus.grid_re}, 32'd0);
      check_eq("rst:px_re", {31'b0, bus.px_re}, 32'd0);
      check_eq("rst:out_valid", {31'b0, bus.out_valid}, 32'd0);
      check_eq("rst:grid_addr", bus.grid_addr, 32'd0);
      check_eq("rst:out_node", bus.out_node, 32'd0);
      check_eq("rst:placed", placed_cnt, 32'd0);
      check_eq("rst:mismatch", mismatch_cnt, 32'd0);
      check_eq("rst:dup", dup_cnt, 32'd0);
      reset = 1'b0;

      // All empty: 36 cells at READ_LAT+2 cycles each.
      clear_mems();
      run_scan("empty", 0, cyc);
      check_eq("empty:cycles", 32'(cyc), 32'(NC * 4));
      check_eq("empty:placed_const", placed_cnt, 32'd0);

      // Single consistent node at cell 14 = (2,2).
      clear_mems();
      grid_mem[14] = 3; posx_mem[3] = 2; posy_mem[3] = 2;
      run_scan("single", 0, cyc);
      check_eq("single:placed_const", placed_cnt, 32'd1);

      // Position disagreement plus an out-of-range id in cell 0.
      posy_mem[3] = 4;
      grid_mem[0] = 200;
      run_scan("mism", 0, cyc);
      check_eq("mism:mismatch_const", mismatch_cnt, 32'd2);

      // Out-of-range id only: no position lookup at all.
      clear_mems();
      grid_mem[0] = 200;
      grid_mem[35] = -7;
      run_scan("badid", 0, cyc);

      // Backpressure: each record stalled for 5 cycles.
      clear_mems();
      grid_mem[14] = 3; posx_mem[3] = 2; posy_mem[3] = 2;
      grid_mem[35] = 9; posx_mem[9] = 5; posy_mem[9] = 5;
      run_scan("bp", 2, cyc);

      // Same node in two cells.
      clear_mems();
      grid_mem[7] = 5; grid_mem[20] = 5; posx_mem[5] = 1; posy_mem[5] = 1;
      run_scan("dup", 0, cyc);
`ifdef PLACEMENT_READBACK_DUP_CHECK_EN
      check_eq("dup:dup_const", dup_cnt, 32'd1);
      check_eq("dup:mism_const", mismatch_cnt, 32'd0);
`else
      check_eq("dup:dup_const", dup_cnt, 32'd0);
      check_eq("dup:mism_const", mismatch_cnt, 32'd1);
`endif

      // Randomized placements with corruption, invalid ids, repeats.
      for (int it = 0; it < 8; it++) begin
         clear_mems();
         for (int c = 0; c < NC; c++) begin
            int r, nd;
            r = int'($urandom_range(0, 9));
            if (r < 4) continue;
            if (r == 9) nd = ($urandom_range(0, 1) == 0) ? 200 + int'($urandom_range(0, 50)) : -2 - int'($urandom_range(0, 9));
            else if (r == 8) nd = int'($urandom_range(0, 7));
            else nd = int'($urandom_range(0, N_NODES - 1));
            grid_mem[c] = nd;
            if (nd >= 0 && nd < N_NODES) begin
               if ($urandom_range(0, 3) != 0) begin
                  posx_mem[nd] = c / N;
                  posy_mem[nd] = c % N;
               end else begin
                  posx_mem[nd] = int'($urandom_range(0, N - 1));
                  posy_mem[nd] = int'($urandom_range(0, N - 1));
               end
            end
         end
         run_scan($sformatf("rand%0d", it), 1, cyc);
      end

      // Reset mid-scan after 10 cells.
      clear_mems();
      for (int c = 0; c < 6; c++) grid_mem[c] = 300;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      gre = 0;
      cyc = 0;
      while (gre < 11 && cyc < 1000) begin
         if (bus.grid_re) gre++;
         if (gre < 11) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
         end
      end
      check_eq("rstmid:reached", 32'(gre), 32'd11);
      check_eq("rstmid:mism_before", mismatch_cnt, 32'd6);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_eq("rstmid:busy", {31'b0, busy}, 32'd0);
      check_eq("rstmid:out_valid", {31'b0, bus.out_valid}, 32'd0);
      check_eq("rstmid:grid_re", {31'b0, bus.grid_re}, 32'd0);
      check_eq("rstmid:placed", placed_cnt, 32'd0);
      check_eq("rstmid:mismatch", mismatch_cnt, 32'd0);
      check_eq("rstmid:dup", dup_cnt, 32'd0);
      ndone = 0;
      for (int i = 0; i < 200; i++) begin
         if (done) ndone++;
         if (bus.grid_re) ndone++;
         @(posedge clk);
         @(negedge clk);
      end
      check_eq("rstmid:quiet", 32'(ndone), 32'd0);
      grid_mem[21] = 11; posx_mem[11] = 3; posy_mem[11] = 3;
      run_scan("after_rst", 0, cyc);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
